// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//
// Groups the signals between the serial-adder controller and the rest of
// the board: the start request, the two serial operand streams coming from
// the operand registers, the load/shift strobes back to those registers,
// and the result/status outputs.
//
//   start         request to begin an operation (sampled in IDLE only)
//   a_bit, b_bit  LSB-first serial operands from the operand registers
//   load, shift   strobes to both operand registers
//   sum, cout     N-bit result and final carry, qualified by done
//   done          one-cycle result-valid pulse
//   busy          high whenever the controller is not idle
//
// master: the board side that issues start and supplies operand bits.
// slave : the controller itself.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int N = 4
) ();
    logic         start;
    logic         a_bit;
    logic         b_bit;
    logic         load;
    logic         shift;
    logic [N-1:0] sum;
    logic         cout;
    logic         done;
    logic         busy;

    modport master (
        output start, a_bit, b_bit,
        input  load, shift, sum, cout, done, busy
    );

    modport slave (
        input  start, a_bit, b_bit,
        output load, shift, sum, cout, done, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Sequencer and bit-serial adder for two parallel-in/serial-out operand
// registers. One operation is LOAD (1 cycle), SHIFT (N cycles), DRAIN
// (1 cycle), DONE (1 cycle). The operand registers present bit k on their
// s_out one cycle after the (k+1)th shift edge, so the adder runs one cycle
// behind the shift strobe: it is enabled in SHIFT from the second cycle on
// and in DRAIN, giving exactly N add edges. Each add edge shifts the sum bit
// into the top of a serial-in/parallel-out result register, so after N adds
// the LSB has reached sum[0].
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low; clears all state immediately
//   bus    serial_add_ctrl_if.slave (start, a_bit, b_bit in;
//          load, shift, sum, cout, done, busy out)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [N-1:0]       sum_q;

    logic               last_shift;
    logic               add_en;
    logic               sum_bit;
    logic               carry_d;

    assign last_shift = (cnt_q == CNT_W'(N - 1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_d is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (last_shift) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode: purely from the registered state, so the strobes are
    // glitch-free and have no combinational path from start or the operand
    // bits.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.load  = 1'b0;
        bus.shift = 1'b0;
        bus.done  = 1'b0;
        bus.busy  = 1'b1;
        unique case (state_q)
            S_IDLE:  bus.busy  = 1'b0;
            S_LOAD:  bus.load  = 1'b1;
            S_SHIFT: bus.shift = 1'b1;
            S_DRAIN: ;
            S_DONE:  bus.done  = 1'b1;
            default: bus.busy  = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit-serial full adder. The first SHIFT cycle only moves bit 0 onto the
    // operand registers' outputs, so adding starts one cycle later and the
    // final bit pair is consumed in DRAIN.
    // -----------------------------------------------------------------------
    assign add_en  = ((state_q == S_SHIFT) && (cnt_q != '0)) || (state_q == S_DRAIN);
    assign sum_bit = bus.a_bit ^ bus.b_bit ^ carry_q;
    assign carry_d = (bus.a_bit & bus.b_bit) | (bus.a_bit & carry_q) | (bus.b_bit & carry_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            if (state_q == S_LOAD) begin
                cnt_q   <= '0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                if (state_q == S_SHIFT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (add_en) begin
                    carry_q <= carry_d;
                    sum_q   <= {sum_bit, sum_q[N-1:1]};
                end
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl with N=4. The bench models the two
// upstream operand registers (load forces s_out=0, shift moves bit 0 onto
// s_out). Stimulus pushes hand-computed {cout,sum} values into a scoreboard
// queue; a monitor on the falling edge pops and compares whenever done is
// high, and also tracks the expected load/shift/done/busy timeline starting
// from each load pulse.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int N = 4;

    logic clk;
    logic reset;

    serial_add_ctrl_if #(.N(N)) bus ();

    serial_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected {cout,sum} and queue of operand pairs {a,b}.
    logic [N:0]     exp_q[$];
    logic [2*N-1:0] opnd_q[$];

    // Cycle counter for spacing checks.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Upstream operand register model
    // -----------------------------------------------------------------------
    logic [N-1:0]   reg_a, reg_b;
    logic           sa, sb;
    logic [2*N-1:0] pair;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_a <= '0;
            reg_b <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
        end else if (bus.load) begin
            check("operand_q_nonempty", 32'(opnd_q.size() != 0), 32'd1);
            if (opnd_q.size() != 0) begin
                pair = opnd_q.pop_front();
                reg_a <= pair[2*N-1:N];
                reg_b <= pair[N-1:0];
            end
            sa <= 1'b0;
            sb <= 1'b0;
        end else if (bus.shift) begin
            sa    <= reg_a[0];
            sb    <= reg_b[0];
            reg_a <= reg_a >> 1;
            reg_b <= reg_b >> 1;
        end
    end

    assign bus.a_bit = sa;
    assign bus.b_bit = sb;

    // -----------------------------------------------------------------------
    // Monitor: control timeline, shift count and scoreboard
    // -----------------------------------------------------------------------
    int         ph        = -1;
    int         shift_cnt = 0;
    int         done_cnt  = 0;
    logic [3:0] ctrl_exp;
    logic [N:0] exp_res;

    always @(negedge clk) begin
        if (!reset) begin
            ph = -1;
            check("reset_ctrl", 32'({bus.load, bus.shift, bus.done, bus.busy}), 32'd0);
        end else begin
            if (ph >= 0) begin
                ph++;
                if (ph > N + 2) ph = -1;
            end else if (bus.load) begin
                ph = 0;
            end
            ctrl_exp = {ph == 0, (ph >= 1) && (ph <= N), ph == N + 2, ph >= 0};
            check("ctrl_timeline", 32'({bus.load, bus.shift, bus.done, bus.busy}), 32'(ctrl_exp));
            check("load_shift_excl", 32'(bus.load & bus.shift), 32'd0);

            if (bus.load) shift_cnt = 0;
            if (bus.shift) shift_cnt++;

            if (bus.done) begin
                done_cnt++;
                check("shift_count", 32'(shift_cnt), 32'(N));
                check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_res = exp_q.pop_front();
                    check("result", 32'({bus.cout, bus.sum}), 32'(exp_res));
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    // Pulse start so it is sampled at the next rising edge; returns in cycle 1.
    task automatic start_op();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] res);
        opnd_q.push_back({a, b});
        exp_q.push_back(res);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N:0] res);
        push_op(a, b, res);
        start_op();
        wait_done(40);
    endtask

    // -----------------------------------------------------------------------
    // Directed tests
    // -----------------------------------------------------------------------
    int d0, d1, d2, dc;

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;

        // Reset values, during and after reset.
        repeat (2) @(negedge clk);
        check("reset_vals", 32'({bus.load, bus.shift, bus.done, bus.busy, bus.cout, bus.sum}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_vals", 32'({bus.load, bus.shift, bus.done, bus.busy, bus.cout, bus.sum}), 32'd0);

        // 0101 + 0011 with exact cycle-by-cycle strobe timing.
        push_op(4'b0101, 4'b0011, 5'b0_1000);
        start_op();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_cycle%0d", k), 32'({bus.load, bus.shift, bus.done}),
                  32'({k == 1, (k >= 2) && (k <= 5), k == 7}));
        end

        // Overflow and boundary operands.
        run_op(4'b1111, 4'b0001, 5'b1_0000);
        run_op(4'b1111, 4'b1111, 5'b1_1110);
        run_op(4'b0000, 4'b0000, 5'b0_0000);
        @(negedge clk);

        // Spurious start pulses in cycles 2, 4 and the DONE cycle.
        dc = done_cnt;
        push_op(4'b1001, 4'b0100, 5'b0_1101);
        start_op();                        // now in cycle 1
        @(posedge clk); #1 bus.start = 1'b1; // cycle 2
        @(posedge clk); #1 bus.start = 1'b0; // cycle 3
        @(posedge clk); #1 bus.start = 1'b1; // cycle 4
        @(posedge clk); #1 bus.start = 1'b0; // cycle 5
        @(posedge clk);                      // cycle 6
        @(posedge clk); #1 bus.start = 1'b1; // cycle 7 (DONE)
        @(posedge clk); #1 bus.start = 1'b0; // cycle 8 (IDLE)
        repeat (12) @(negedge clk);
        check("spurious_done_count", 32'(done_cnt - dc), 32'd1);
        check("spurious_idle", 32'(bus.busy), 32'd0);

        // start held high for three back-to-back operations.
        push_op(4'd1, 4'd2, 5'b0_0011);
        push_op(4'd7, 4'd8, 5'b0_1111);
        push_op(4'd9, 4'd9, 5'b1_0010);
        @(negedge clk);
        bus.start = 1'b1;
        wait_done(40); d0 = cyc;
        wait_done(40); d1 = cyc;
        wait_done(40); d2 = cyc;
        bus.start = 1'b0;
        check("b2b_spacing_1", 32'(d1 - d0), 32'(N + 4));
        check("b2b_spacing_2", 32'(d2 - d1), 32'(N + 4));
        repeat (4) @(negedge clk);

        // Reset in the third SHIFT cycle aborts the operation.
        opnd_q.push_back({4'd12, 4'd3});
        start_op();                        // cycle 1
        @(posedge clk);                    // cycle 2
        @(posedge clk);                    // cycle 3
        @(posedge clk);                    // cycle 4
        #1;
        check("pre_reset_shift", 32'(bus.shift), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.load, bus.shift, bus.done, bus.busy, bus.cout, bus.sum}), 32'd0);
        opnd_q.delete();
        dc = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'({bus.busy, bus.done}), 32'd0);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        run_op(4'd6, 4'd5, 5'b0_1011);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Downstream consumer and sequencer for the two parallel-in/serial-out operand registers of the serial adder. Drives their `load`/`shift` controls, consumes their LSB-first `s_out` streams through a one-bit full adder with a carry flip-flop, and assembles the sum in a serial-in/parallel-out result register. Presents an N-bit sum, carry-out and a one-cycle `done` pulse to the board-level top.

## Interface

Parameters:
- `N`, 4, operand/sum width; also the number of shift cycles issued per operation.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it clears all state immediately.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `a_bit`  in  1  serial operand A, from the A operand register's `s_out`.
- `b_bit`  in  1  serial operand B, from the B operand register's `s_out`.
- `load`  out  1  parallel-load strobe to both operand registers.
- `shift`  out  1  shift strobe to both operand registers.
- `sum`  out  N  result register; valid while `done`=1, held until next LOAD.
- `cout`  out  1  final carry; same validity as `sum`.
- `done`  out  1  one-cycle pulse, result valid.
- `busy`  out  1  high in every state except IDLE.

## Operation

- Upstream operand registers: `load` copies the parallel input and forces `s_out`=0. Each `shift` edge registers bit[0] onto `s_out` and shifts right. So bit k of an operand is visible on `a_bit`/`b_bit` in the cycle after the (k+1)th shift edge.
- FSM states: IDLE, LOAD, SHIFT, DRAIN, DONE.
  - IDLE: outputs inactive. `start`=1 → LOAD.
  - LOAD: `load`=1 for exactly one cycle. Carry FF cleared to 0; `sum` cleared to 0; shift counter cleared to 0 → SHIFT.
  - SHIFT: `shift`=1 every cycle. Counter increments 0..N-1 → DRAIN when counter = N-1.
  - DRAIN: `shift`=0. One final add cycle → DONE.
  - DONE: `done`=1 for one cycle → IDLE unconditionally.
- Add enable is high in SHIFT with counter ≥ 1, and in DRAIN. That is exactly N add edges, each consuming one valid bit pair.
- On each add edge:
  - s = a_bit ^ b_bit ^ c
  - c ← majority(a_bit, b_bit, c)
  - sum ← {s, sum[N-1:1]}
- After N adds, sum[0] holds the LSB. Arithmetic is modulo 2^N, with overflow reported on `cout`.
- `cout` is the carry FF output.
- `load` and `shift` are never high in the same cycle.
- `start` is ignored while `busy`=1, including in DONE.

## Timing

- Reset values: `load`=0, `shift`=0, `sum`=0, `cout`=0, `done`=0, `busy`=0. State = IDLE, counter = 0, carry = 0.
- `load`, `shift`, `done` and `busy` are decoded from registered state (glitch-free, no combinational path from inputs).
- Latency: if `start` is sampled at edge E0, then:
  - `load` is high in cycle 1;
  - `shift` is high in cycles 2..N+1;
  - DRAIN is cycle N+2;
  - `done`=1 in cycle N+3 after E0.
- With `start` held high, back-to-back operations repeat every N+4 cycles (DONE → IDLE → LOAD).
- Reset asserted mid-operation (any state): immediate return to reset values, no `done`, and `load`/`shift` drop at once. On release, stays in IDLE until `start`.
- `sum`/`cout` change during SHIFT/DRAIN. The consumer must qualify them with `done`, or read them in IDLE after `done`.
- The block does not reset the operand registers; the integration top drives their active-high reset from the inverted `reset`.

## Test plan

- N=4, A=0101, B=0011, pulse `start`: `load` in cycle 1, `shift` high 4 cycles, `done` in cycle 7, `sum`=1000, `cout`=0.
- A=1111, B=0001: `sum`=0000, `cout`=1. A=1111, B=1111: `sum`=1110, `cout`=1. A=B=0000: `sum`=0000, `cout`=0.
- Pulse `start` again in cycles 2, 4 and the DONE cycle of an operation: exactly one `done`. Result unaffected, and no new LOAD until IDLE.
- `start` held high for 3 operations (1+2, 7+8, 9+9): `done` pulses 8 cycles apart. Sums 0011, 1111/`cout`0, 0010/`cout`1.
- Assert `reset` low during the 3rd SHIFT cycle: all outputs 0 immediately, `done` never pulses. After release, a new 6+5 operation yields 1011, `cout`=0.
- Bench-side check: `load`∧`shift` never 1 in the same cycle; `busy`=0 only in IDLE; exactly N `shift` cycles per operation.
